// File: rtl/poly_envelope_generator.sv
// Multi-voice ADSR envelope generator with a saturating voice mixer.
// One poly_envelope_voice instance per voice holds that voice's ADSR state
// and level. The top level owns the shared sample-tick divider, the gate
// edge detection and the signed mix of all enveloped voices.

// ---------------------------------------------------------------------------
// Per-voice ADSR state machine. Level and state only move on a tick.
// ---------------------------------------------------------------------------
module poly_envelope_voice #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             trig,
    input  logic             press,
    input  logic [WIDTH-1:0] attack_rate,
    input  logic [WIDTH-1:0] decay_rate,
    input  logic [WIDTH-1:0] sustain_level,
    input  logic [WIDTH-1:0] release_rate,
    output logic [WIDTH-1:0] level,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] MAX = '1;

    state_t            st_q, st_d;
    logic [WIDTH-1:0]  lvl_q, lvl_d;

    // One extra bit so overflow (attack) and underflow (decay/release)
    // are visible before clamping.
    logic [WIDTH:0]        att_sum;
    logic signed [WIDTH:0] dec_diff;
    logic signed [WIDTH:0] rel_diff;

    assign att_sum  = {1'b0, lvl_q} + {1'b0, attack_rate};
    assign dec_diff = $signed({1'b0, lvl_q}) - $signed({1'b0, decay_rate});
    assign rel_diff = $signed({1'b0, lvl_q}) - $signed({1'b0, release_rate});

    // State and level registers; reset parks the voice silent in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q  <= ST_IDLE;
            lvl_q <= '0;
        end else begin
            st_q  <= st_d;
            lvl_q <= lvl_d;
        end
    end

    // Next state/level: retrigger beats gate release, which beats the
    // normal per-state envelope step.
    always_comb begin
        st_d  = st_q;
        lvl_d = lvl_q;
        if (tick) begin
            if (trig) begin
                // Retrigger restarts the attack from wherever the level is.
                st_d = ST_ATTACK;
            end else if (!press && (st_q == ST_ATTACK || st_q == ST_DECAY ||
                                    st_q == ST_SUSTAIN)) begin
                st_d = ST_RELEASE;
            end else begin
                case (st_q)
                    ST_IDLE: begin
                        lvl_d = '0;
                    end
                    ST_ATTACK: begin
                        lvl_d = att_sum[WIDTH] ? MAX : att_sum[WIDTH-1:0];
                        if (lvl_d == MAX) st_d = ST_DECAY;
                    end
                    ST_DECAY: begin
                        // Also pulls the level up if sustain sits above it.
                        if (dec_diff < $signed({1'b0, sustain_level}))
                            lvl_d = sustain_level;
                        else
                            lvl_d = dec_diff[WIDTH-1:0];
                        if (lvl_d == sustain_level) st_d = ST_SUSTAIN;
                    end
                    ST_SUSTAIN: begin
                        lvl_d = sustain_level;
                    end
                    ST_RELEASE: begin
                        lvl_d = rel_diff[WIDTH] ? '0 : rel_diff[WIDTH-1:0];
                        if (lvl_d == '0) st_d = ST_IDLE;
                    end
                    default: begin
                        st_d  = ST_IDLE;
                        lvl_d = '0;
                    end
                endcase
            end
        end
    end

    assign level = lvl_q;
    assign state = st_q;

endmodule

// ---------------------------------------------------------------------------
// Top level: tick divider, gate edge detect, voice array and mixer.
// ---------------------------------------------------------------------------
module poly_envelope_generator #(
    parameter int NUM_VOICES     = 4,
    parameter int WIDTH          = 12,
    parameter int CPU_CLOCK_FREQ = 100_000_000,
    parameter int SAMPLE_RATE    = 100_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_VOICES-1:0]       press,
    input  logic [WIDTH-1:0]            attack_rate,
    input  logic [WIDTH-1:0]            decay_rate,
    input  logic [WIDTH-1:0]            sustain_level,
    input  logic [WIDTH-1:0]            release_rate,
    input  logic [NUM_VOICES*WIDTH-1:0] voice_in,
    output logic [NUM_VOICES*WIDTH-1:0] env,
    output logic [NUM_VOICES*3-1:0]     env_state,
    output logic                        sample_tick,
    output logic [WIDTH-1:0]            wave
);

    localparam int TICK_DIV = CPU_CLOCK_FREQ / SAMPLE_RATE;
    localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // Mix accumulator wide enough for NUM_VOICES full-scale products.
    localparam int SW       = 2*WIDTH + 1 + $clog2(NUM_VOICES);

    localparam logic [CW-1:0]        TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic signed [SW-1:0] WAVE_MAX  = SW'((1 << (WIDTH-1)) - 1);
    localparam logic signed [SW-1:0] WAVE_MIN  = ~WAVE_MAX;

    // Packed per-voice views of the flat ports.
    logic [NUM_VOICES-1:0][WIDTH-1:0] voice_v;
    logic [NUM_VOICES-1:0][WIDTH-1:0] env_v;
    logic [NUM_VOICES-1:0][2:0]       st_v;

    assign voice_v   = voice_in;
    assign env       = env_v;
    assign env_state = st_v;

    logic [CW-1:0]         cnt;
    logic                  tick;
    logic [NUM_VOICES-1:0] press_q;
    logic [NUM_VOICES-1:0] pending;
    logic [NUM_VOICES-1:0] rise;
    logic [NUM_VOICES-1:0] trig;

    assign tick = (cnt == TICK_LAST);

    // Sample-rate divider; sample_tick marks the cycle envelopes changed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            sample_tick <= 1'b0;
        end else begin
            cnt         <= tick ? '0 : cnt + 1'b1;
            sample_tick <= tick;
        end
    end

    // A press edge is latched until the next tick so gate pulses shorter
    // than a tick period still retrigger. An edge landing on the tick cycle
    // itself is consumed directly through trig.
    assign rise = press & ~press_q;
    assign trig = pending | rise;

    // Gate delay and pending-retrigger flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_q <= '0;
            pending <= '0;
        end else begin
            press_q <= press;
            pending <= tick ? '0 : (pending | rise);
        end
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        poly_envelope_voice #(
            .WIDTH(WIDTH)
        ) u_voice (
            .clk          (clk),
            .rst          (rst),
            .tick         (tick),
            .trig         (trig[i]),
            .press        (press[i]),
            .attack_rate  (attack_rate),
            .decay_rate   (decay_rate),
            .sustain_level(sustain_level),
            .release_rate (release_rate),
            .level        (env_v[i]),
            .state        (st_v[i])
        );
    end

    logic signed [SW-1:0] mix_sum;
    logic signed [SW-1:0] mix_shr;
    logic [WIDTH-1:0]     wave_d;

    // Signed voice times unsigned envelope, summed, floored back to WIDTH
    // bits and saturated.
    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            logic signed [SW-1:0] vx;
            logic signed [SW-1:0] ex;
            vx      = SW'($signed(voice_v[i]));
            ex      = SW'($signed({1'b0, env_v[i]}));
            mix_sum = mix_sum + vx * ex;
        end
        mix_shr = mix_sum >>> WIDTH;
        if (mix_shr > WAVE_MAX)
            wave_d = WAVE_MAX[WIDTH-1:0];
        else if (mix_shr < WAVE_MIN)
            wave_d = WAVE_MIN[WIDTH-1:0];
        else
            wave_d = mix_shr[WIDTH-1:0];
    end

    // Output register for the mix.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wave <= '0;
        else      wave <= wave_d;
    end

endmodule

// File: tb/tb_poly_envelope_generator.sv
// Bench for poly_envelope_generator (4 voices, 12 bit, tick every 4 clocks).
// Envelope expectations are queued when stimulus is applied and checked on
// each sample_tick; mix and reset behaviour are checked inline.
module tb_poly_envelope_generator;

    localparam int NV = 4;
    localparam int W  = 12;

    localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NV-1:0]     press;
    logic [W-1:0]      attack_rate, decay_rate, sustain_level, release_rate;
    logic [NV*W-1:0]   voice_in;
    logic [NV*W-1:0]   env;
    logic [NV*3-1:0]   env_state;
    logic              sample_tick;
    logic [W-1:0]      wave;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [NV*W-1:0] env;
        logic [NV*3-1:0] st;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    poly_envelope_generator #(
        .NUM_VOICES    (NV),
        .WIDTH         (W),
        .CPU_CLOCK_FREQ(100_000_000),
        .SAMPLE_RATE   (25_000_000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .press        (press),
        .attack_rate  (attack_rate),
        .decay_rate   (decay_rate),
        .sustain_level(sustain_level),
        .release_rate (release_rate),
        .voice_in     (voice_in),
        .env          (env),
        .env_state    (env_state),
        .sample_tick  (sample_tick),
        .wave         (wave)
    );

    // Expected value: voice 0 at lvl/st, other voices silent and idle.
    function automatic exp_t v0(input int lvl, input int st);
        exp_t e;
        logic [W-1:0] l;
        logic [2:0]   s;
        l = lvl[W-1:0];
        s = st[2:0];
        e.env = {{(NV-1)*W{1'b0}}, l};
        e.st  = {{(NV-1)*3{1'b0}}, s};
        return e;
    endfunction

    // Expected value: every voice at lvl/st.
    function automatic exp_t vall(input int lvl, input int st);
        exp_t e;
        logic [W-1:0] l;
        logic [2:0]   s;
        l = lvl[W-1:0];
        s = st[2:0];
        e.env = {NV{l}};
        e.st  = {NV{s}};
        return e;
    endfunction

    // Scoreboard: each sample_tick consumes the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && sample_tick && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_total++;
            if (env !== e.env || env_state !== e.st)
                $display("FAIL env_tick @%0t: env=%h state=%h, expected env=%h state=%h",
                         $time, env, env_state, e.env, e.st);
            else
                n_pass++;
        end
    end

    // Let the scoreboard empty, bounded; a stall counts as a failure.
    task automatic drain(input string name);
        for (int k = 0; k < 200 && sb_q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() > 0) begin
            n_total++;
            $display("FAIL %s timeout: %0d expected ticks never seen", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (env !== '0) $display("FAIL reset_env: got %h want 0", env); else n_pass++;
        n_total++; if (env_state !== '0) $display("FAIL reset_state: got %h want 0", env_state); else n_pass++;
        n_total++; if (wave !== '0) $display("FAIL reset_wave: got %h want 0", wave); else n_pass++;
        n_total++; if (sample_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", sample_tick); else n_pass++;
        #1 rst = 1'b1;
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic test_attack();
        attack_rate = 12'd1024; decay_rate = 12'd512;
        sustain_level = 12'd3000; release_rate = 12'd1000;
        press = 4'b0001;
        sb_q.push_back(v0(0, S_ATT));
        sb_q.push_back(v0(1024, S_ATT));
        sb_q.push_back(v0(2048, S_ATT));
        sb_q.push_back(v0(3072, S_ATT));
        sb_q.push_back(v0(4095, S_DEC));
        drain("attack");
    endtask

    task automatic test_decay_sustain();
        sb_q.push_back(v0(3583, S_DEC));
        sb_q.push_back(v0(3071, S_DEC));
        sb_q.push_back(v0(3000, S_SUS));
        drain("decay");
        sustain_level = 12'd2000;
        sb_q.push_back(v0(2000, S_SUS));
        drain("sustain_track");
    endtask

    task automatic test_release();
        press = 4'b0000; release_rate = 12'd1000;
        sb_q.push_back(v0(2000, S_REL));
        sb_q.push_back(v0(1000, S_REL));
        sb_q.push_back(v0(0, S_IDLE));
        drain("release");
    endtask

    task automatic test_retrigger();
        attack_rate = 12'd4095; decay_rate = 12'd4095; sustain_level = 12'd2000;
        press = 4'b0001;
        sb_q.push_back(v0(0, S_ATT));
        sb_q.push_back(v0(4095, S_DEC));
        sb_q.push_back(v0(2000, S_SUS));
        drain("retrig_setup");
        press = 4'b0000;
        sb_q.push_back(v0(2000, S_REL));
        sb_q.push_back(v0(1000, S_REL));
        drain("retrig_release");
        attack_rate = 12'd1024;
        press = 4'b0001;
        sb_q.push_back(v0(1000, S_ATT));
        sb_q.push_back(v0(2024, S_ATT));
        sb_q.push_back(v0(3048, S_ATT));
        sb_q.push_back(v0(4072, S_ATT));
        sb_q.push_back(v0(4095, S_DEC));
        drain("retrigger");
    endtask

    task automatic test_short_pulse();
        press = 4'b0000; release_rate = 12'd1000;
        sb_q.push_back(v0(4095, S_REL));
        drain("pulse_setup");
        // One-cycle gate pulse well clear of the next tick.
        sb_q.push_back(v0(4095, S_ATT));
        sb_q.push_back(v0(4095, S_REL));
        sb_q.push_back(v0(3095, S_REL));
        press = 4'b0001;
        @(negedge clk);
        #1 press = 4'b0000;
        drain("short_pulse");
    endtask

    task automatic test_mix();
        attack_rate = 12'd4095; decay_rate = 12'd0; sustain_level = 12'd0;
        release_rate = 12'd4095; press = 4'b0000; voice_in = '0;
        repeat (30) @(negedge clk);
        n_total++; if (env !== '0) $display("FAIL mix_silent_env: got %h want 0", env); else n_pass++;
        press = 4'b0001;
        repeat (30) @(negedge clk);
        n_total++; if (env[W-1:0] !== 12'd4095) $display("FAIL mix_env0_hold: got %0d want 4095", env[W-1:0]); else n_pass++;
        voice_in = {12'd0, 12'd0, 12'd0, 12'd2047};
        repeat (2) @(negedge clk);
        n_total++; if (wave !== 12'd2046) $display("FAIL mix_single: got %0d want 2046", $signed(wave)); else n_pass++;
        voice_in = {12'd0, 12'd0, 12'd0, 12'hFFF};
        repeat (2) @(negedge clk);
        n_total++; if (wave !== 12'hFFF) $display("FAIL mix_floor_neg: got %0d want -1", $signed(wave)); else n_pass++;
        press = 4'b1111;
        repeat (30) @(negedge clk);
        n_total++; if (env !== {NV{12'd4095}}) $display("FAIL mix_all_env: got %h want all fff", env); else n_pass++;
        voice_in = {NV{12'd2047}};
        repeat (2) @(negedge clk);
        n_total++; if (wave !== 12'h7FF) $display("FAIL mix_sat_pos: got %0d want 2047", $signed(wave)); else n_pass++;
        voice_in = {NV{12'h800}};
        repeat (2) @(negedge clk);
        n_total++; if (wave !== 12'h800) $display("FAIL mix_sat_neg: got %0d want -2048", $signed(wave)); else n_pass++;
        press = 4'b0000;
        repeat (30) @(negedge clk);
        n_total++; if (env_state !== '0) $display("FAIL mix_idle_state: got %h want 0", env_state); else n_pass++;
        n_total++; if (wave !== '0) $display("FAIL mix_zero_env: got %0d want 0", $signed(wave)); else n_pass++;
        #1;
    endtask

    task automatic test_async_reset();
        attack_rate = 12'd1024; decay_rate = 12'd0;
        voice_in = {NV{12'd2047}};
        press = 4'b1111;
        sb_q.push_back(vall(0, S_ATT));
        sb_q.push_back(vall(1024, S_ATT));
        sb_q.push_back(vall(2048, S_ATT));
        drain("areset_setup");
        // Just after a tick: sample_tick high, wave reflects env 1024.
        n_total++; if (sample_tick !== 1'b1) $display("FAIL areset_pre_tick: got %b want 1", sample_tick); else n_pass++;
        n_total++; if (wave !== 12'h7FF) $display("FAIL areset_pre_wave: got %0d want 2047", $signed(wave)); else n_pass++;
        rst = 1'b0;
        #2;
        n_total++; if (env !== '0) $display("FAIL areset_env: got %h want 0", env); else n_pass++;
        n_total++; if (env_state !== '0) $display("FAIL areset_state: got %h want 0", env_state); else n_pass++;
        n_total++; if (wave !== '0) $display("FAIL areset_wave: got %h want 0", wave); else n_pass++;
        n_total++; if (sample_tick !== 1'b0) $display("FAIL areset_tick: got %b want 0", sample_tick); else n_pass++;
        @(negedge clk);
        #1 rst = 1'b1;
        sb_q.push_back(vall(0, S_ATT));
        sb_q.push_back(vall(1024, S_ATT));
        drain("areset_resume");
    endtask

    initial begin
        rst = 1'b0; press = '0; voice_in = '0;
        attack_rate = '0; decay_rate = '0; sustain_level = '0; release_rate = '0;
        test_reset();
        test_attack();
        test_decay_sustain();
        test_release();
        test_retrigger();
        test_short_pulse();
        test_mix();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
